// File: rtl/rv_divide_ctrl_pkg.sv
// Shared definitions for the divide controller: funct3 codes, FSM encoding,
// divide constants and the RISC-V special-case resolver.
package rv_divide_ctrl_pkg;

  localparam int unsigned DIVC_XLEN = 32;

  localparam logic [2:0] FUNC_DIV  = 3'b100;
  localparam logic [2:0] FUNC_DIVU = 3'b101;
  localparam logic [2:0] FUNC_REM  = 3'b110;
  localparam logic [2:0] FUNC_REMU = 3'b111;

  localparam logic [DIVC_XLEN-1:0] DIVC_INT_MIN   = 32'h8000_0000;
  localparam logic [DIVC_XLEN-1:0] DIVC_ALL_ONES  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    DIVC_IDLE   = 3'd0,
    DIVC_FAST   = 3'd1,
    DIVC_START  = 3'd2,
    DIVC_WAIT   = 3'd3,
    DIVC_RESULT = 3'd4
  } divc_state_e;

  typedef struct packed {
    logic                 hit;
    logic [DIVC_XLEN-1:0] quot;
    logic [DIVC_XLEN-1:0] rem;
  } divc_pair_t;

  // Divide-by-zero takes priority over signed overflow.
  function automatic divc_pair_t divc_special(input logic [DIVC_XLEN-1:0] rs1,
                                              input logic [DIVC_XLEN-1:0] rs2,
                                              input logic                 sgn);
    divc_pair_t res;
    if (rs2 == 32'd0) begin
      res.hit  = 1'b1;
      res.quot = DIVC_ALL_ONES;
      res.rem  = rs1;
    end else if (sgn && (rs1 == DIVC_INT_MIN) && (rs2 == DIVC_ALL_ONES)) begin
      res.hit  = 1'b1;
      res.quot = DIVC_INT_MIN;
      res.rem  = 32'd0;
    end else begin
      res.hit  = 1'b0;
      res.quot = 32'd0;
      res.rem  = 32'd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/rv_divide_opcache.sv
// Single-entry cache of the last core quotient/remainder pair, tagged by
// operands and signedness.
module rv_divide_opcache
  import rv_divide_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIVC_XLEN-1:0] lk_rs1_i,
  input  logic [DIVC_XLEN-1:0] lk_rs2_i,
  input  logic                 lk_signed_i,
  output logic                 hit_o,
  output logic [DIVC_XLEN-1:0] quot_o,
  output logic [DIVC_XLEN-1:0] rem_o,
  input  logic                 wr_i,
  input  logic [DIVC_XLEN-1:0] wr_rs1_i,
  input  logic [DIVC_XLEN-1:0] wr_rs2_i,
  input  logic                 wr_signed_i,
  input  logic [DIVC_XLEN-1:0] wr_quot_i,
  input  logic [DIVC_XLEN-1:0] wr_rem_i,
  input  logic                 inval_i
);

  logic                 valid_q, valid_d;
  logic                 signed_q, signed_d;
  logic [DIVC_XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, quot_q, quot_d, rem_q, rem_d;

  assign hit_o  = valid_q && (rs1_q == lk_rs1_i) && (rs2_q == lk_rs2_i) &&
                  (signed_q == lk_signed_i);
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

  // Entry update: invalidate beats a write.
  always_comb begin
    valid_d  = valid_q;
    signed_d = signed_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    if (inval_i) begin
      valid_d = 1'b0;
    end else if (wr_i) begin
      valid_d  = 1'b1;
      signed_d = wr_signed_i;
      rs1_d    = wr_rs1_i;
      rs2_d    = wr_rs2_i;
      quot_d   = wr_quot_i;
      rem_d    = wr_rem_i;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      signed_q <= 1'b0;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      quot_q   <= 32'd0;
      rem_q    <= 32'd0;
    end else begin
      valid_q  <= valid_d;
      signed_q <= signed_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
    end
  end

endmodule

// File: rtl/rv_divide_ctrl.sv
// Execute-stage divide controller: resolves special cases and cache hits
// locally, otherwise sequences the shared iterative divider core.
module rv_divide_ctrl
  import rv_divide_ctrl_pkg::*;
#(
  parameter bit G_CACHE_EN     = 1'b1,
  parameter bit G_FAST_SPECIAL = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 x_stall_i,
  input  logic                 x_kill_i,
  output logic                 x_stall_req_o,
  input  logic                 d_valid_i,
  input  logic                 d_is_divide_i,
  input  logic [2:0]           d_fun_i,
  input  logic [DIVC_XLEN-1:0] d_rs1_i,
  input  logic [DIVC_XLEN-1:0] d_rs2_i,
  output logic [DIVC_XLEN-1:0] x_rd_o,
  output logic                 x_rd_valid_o,
  output logic                 div_start_o,
  output logic                 div_signed_o,
  output logic [DIVC_XLEN-1:0] div_rs1_o,
  output logic [DIVC_XLEN-1:0] div_rs2_o,
  output logic                 div_abort_o,
  input  logic                 div_done_i,
  input  logic [DIVC_XLEN-1:0] div_quot_i,
  input  logic [DIVC_XLEN-1:0] div_rem_i
);

  divc_state_e          state_q, state_d;
  logic [DIVC_XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DIVC_XLEN-1:0] fast_val_q, fast_val_d, x_rd_q, x_rd_d;
  logic                 signed_q, signed_d, want_rem_q, want_rem_d, rd_valid_q, rd_valid_d;

  logic                 accept_s, in_signed_s, in_want_rem_s, use_special_s, fast_s;
  logic                 kill_core_s, core_done_s, cache_hit_s;
  logic [DIVC_XLEN-1:0] cache_quot_s, cache_rem_s;
  divc_pair_t           special_s;

  assign accept_s      = (state_q == DIVC_IDLE) && !x_stall_i && !x_kill_i &&
                         d_valid_i && d_is_divide_i;
  assign in_signed_s   = (d_fun_i == FUNC_DIV) || (d_fun_i == FUNC_REM);
  assign in_want_rem_s = (d_fun_i == FUNC_REM) || (d_fun_i == FUNC_REMU);
  assign special_s     = divc_special(d_rs1_i, d_rs2_i, in_signed_s);
  assign use_special_s = G_FAST_SPECIAL && special_s.hit;
  assign fast_s        = use_special_s || cache_hit_s;
  assign kill_core_s   = x_kill_i && ((state_q == DIVC_START) || (state_q == DIVC_WAIT));
  assign core_done_s   = (state_q == DIVC_WAIT) && div_done_i && !x_kill_i;

  generate
    if (G_CACHE_EN) begin : g_cache
      rv_divide_opcache u_opcache (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .lk_rs1_i    (d_rs1_i),
        .lk_rs2_i    (d_rs2_i),
        .lk_signed_i (in_signed_s),
        .hit_o       (cache_hit_s),
        .quot_o      (cache_quot_s),
        .rem_o       (cache_rem_s),
        .wr_i        (core_done_s),
        .wr_rs1_i    (rs1_q),
        .wr_rs2_i    (rs2_q),
        .wr_signed_i (signed_q),
        .wr_quot_i   (div_quot_i),
        .wr_rem_i    (div_rem_i),
        .inval_i     (kill_core_s)
      );
    end else begin : g_no_cache
      assign cache_hit_s  = 1'b0;
      assign cache_quot_s = 32'd0;
      assign cache_rem_s  = 32'd0;
    end
  endgenerate

  assign x_stall_req_o = accept_s || ((state_q != DIVC_IDLE) && (state_q != DIVC_RESULT));
  assign div_start_o   = (state_q == DIVC_START) && !x_kill_i;
  assign div_abort_o   = kill_core_s;
  assign div_signed_o  = signed_q;
  assign div_rs1_o     = rs1_q;
  assign div_rs2_o     = rs2_q;
  assign x_rd_o        = x_rd_q;
  assign x_rd_valid_o  = rd_valid_q;

  // Next-state and result selection.
  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    signed_d   = signed_q;
    want_rem_d = want_rem_q;
    fast_val_d = fast_val_q;
    x_rd_d     = x_rd_q;
    rd_valid_d = 1'b0;
    case (state_q)
      DIVC_IDLE: begin
        if (accept_s) begin
          rs1_d      = d_rs1_i;
          rs2_d      = d_rs2_i;
          signed_d   = in_signed_s;
          want_rem_d = in_want_rem_s;
          if (use_special_s) begin
            fast_val_d = in_want_rem_s ? special_s.rem : special_s.quot;
          end else begin
            fast_val_d = in_want_rem_s ? cache_rem_s : cache_quot_s;
          end
          state_d = fast_s ? DIVC_FAST : DIVC_START;
        end else begin
          state_d = DIVC_IDLE;
        end
      end
      DIVC_FAST: begin
        x_rd_d     = fast_val_q;
        rd_valid_d = 1'b1;
        state_d    = DIVC_RESULT;
      end
      DIVC_START: begin
        state_d = x_kill_i ? DIVC_IDLE : DIVC_WAIT;
      end
      DIVC_WAIT: begin
        if (x_kill_i) begin
          state_d = DIVC_IDLE;
        end else if (div_done_i) begin
          x_rd_d     = want_rem_q ? div_rem_i : div_quot_i;
          rd_valid_d = 1'b1;
          state_d    = DIVC_RESULT;
        end else begin
          state_d = DIVC_WAIT;
        end
      end
      DIVC_RESULT: state_d = DIVC_IDLE;
      default:     state_d = DIVC_IDLE;
    endcase
  end

  // State, latched operands and registered result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= DIVC_IDLE;
      rs1_q      <= 32'd0;
      rs2_q      <= 32'd0;
      signed_q   <= 1'b0;
      want_rem_q <= 1'b0;
      fast_val_q <= 32'd0;
      x_rd_q     <= 32'd0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      signed_q   <= signed_d;
      want_rem_q <= want_rem_d;
      fast_val_q <= fast_val_d;
      x_rd_q     <= x_rd_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_rv_divide_ctrl.sv
// Self-checking bench for rv_divide_ctrl with a behavioural divider core and
// an arithmetic reference model of results, latency and cache reuse.
module tb_rv_divide_ctrl;
  import rv_divide_ctrl_pkg::*;

  logic        clk, rst;
  logic        x_stall_i, x_kill_i, x_stall_req_o;
  logic        d_valid_i, d_is_divide_i;
  logic [2:0]  d_fun_i;
  logic [31:0] d_rs1_i, d_rs2_i, x_rd_o;
  logic        x_rd_valid_o, div_start_o, div_signed_o, div_abort_o, div_done_i;
  logic [31:0] div_rs1_o, div_rs2_o, div_quot_i, div_rem_i;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_start = 0;
  int n_valid = 0;
  int done_cyc = -1;
  int core_lat = 34;
  bit core_busy = 1'b0;
  int core_cnt = 0;
  logic [31:0] core_q, core_r;

  // Reference cache contents (last operand set that ran the core).
  bit          cval = 1'b0;
  bit          cs = 1'b0;
  logic [31:0] ca = 32'd0, cb = 32'd0;

  rv_divide_ctrl dut (
    .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
    .x_stall_req_o(x_stall_req_o), .d_valid_i(d_valid_i), .d_is_divide_i(d_is_divide_i),
    .d_fun_i(d_fun_i), .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i), .x_rd_o(x_rd_o),
    .x_rd_valid_o(x_rd_valid_o), .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_rs1_o(div_rs1_o), .div_rs2_o(div_rs2_o), .div_abort_o(div_abort_o),
    .div_done_i(div_done_i), .div_quot_i(div_quot_i), .div_rem_i(div_rem_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [63:0] ref_qr(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else if (s) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return {q, r};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 200);
      default: return $urandom;
    endcase
  endfunction

  // Behavioural divider core: done pulse core_lat cycles after start.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      core_busy = 1'b0; div_done_i = 1'b0;
    end else begin
      if (core_busy && core_cnt == 0) begin
        div_done_i = 1'b1; div_quot_i = core_q; div_rem_i = core_r;
        core_busy = 1'b0; done_cyc = cyc;
      end else begin
        div_done_i = 1'b0; div_quot_i = $urandom; div_rem_i = $urandom;
        if (core_busy) core_cnt--;
      end
      if (div_abort_o) core_busy = 1'b0;
      if (div_start_o) begin
        n_start++;
        core_busy = 1'b1;
        core_cnt = core_lat - 1;
        {core_q, core_r} = ref_qr(div_rs1_o, div_rs2_o, div_signed_o);
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (x_rd_valid_o) n_valid++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_op(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input bit kill_fast);
    logic [63:0] qr;
    logic [31:0] exp;
    bit sgn, special, hit, exp_core, got;
    int s0, acc_cyc, vcyc;
    sgn = (fun == FUNC_DIV) || (fun == FUNC_REM);
    qr = ref_qr(a, b, sgn);
    exp = (fun == FUNC_REM || fun == FUNC_REMU) ? qr[31:0] : qr[63:32];
    special = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    hit = cval && a == ca && b == cb && sgn == cs;
    exp_core = !special && !hit;
    core_lat = lat;
    s0 = n_start;
    got = 1'b0;
    vcyc = 0;
    @(negedge clk);
    d_valid_i = 1'b1; d_is_divide_i = 1'b1; d_fun_i = fun; d_rs1_i = a; d_rs2_i = b;
    x_stall_i = 1'b0; x_kill_i = 1'b0;
    #1;
    tests++;
    if (x_stall_req_o !== 1'b1) begin
      fails++; $display("FAIL accept_stall: got %b want 1", x_stall_req_o);
    end
    acc_cyc = cyc;
    @(negedge clk);
    d_valid_i = $urandom; d_is_divide_i = $urandom; d_fun_i = $urandom;
    d_rs1_i = $urandom; d_rs2_i = $urandom; x_stall_i = $urandom;
    x_kill_i = kill_fast && !exp_core;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (x_rd_valid_o) begin
        got = 1'b1; vcyc = cyc; break;
      end
      if (i == 0) begin
        tests++;
        if (x_stall_req_o !== 1'b1) begin
          fails++; $display("FAIL busy_stall: got %b want 1", x_stall_req_o);
        end
      end
      @(negedge clk);
      x_kill_i = 1'b0;
    end
    tests++;
    if (!got) begin
      fails++; $display("FAIL result_timeout: fun=%0d a=%h b=%h no x_rd_valid_o", fun, a, b);
    end else begin
      tests++;
      if (x_rd_o !== exp) begin
        fails++; $display("FAIL result: fun=%0d a=%h b=%h got %h want %h", fun, a, b, x_rd_o, exp);
      end
      tests++;
      if (x_stall_req_o !== 1'b0) begin
        fails++; $display("FAIL result_stall: got %b want 0", x_stall_req_o);
      end
      tests++;
      if (exp_core && vcyc !== done_cyc + 1) begin
        fails++; $display("FAIL core_latency: valid cycle %0d want %0d", vcyc, done_cyc + 1);
      end else if (!exp_core && vcyc !== acc_cyc + 2) begin
        fails++; $display("FAIL fast_latency: valid cycle %0d want %0d", vcyc, acc_cyc + 2);
      end
    end
    tests++;
    if (n_start - s0 !== (exp_core ? 1 : 0)) begin
      fails++; $display("FAIL start_count: fun=%0d a=%h b=%h got %0d want %0d",
                        fun, a, b, n_start - s0, exp_core ? 1 : 0);
    end
    @(negedge clk);
    d_valid_i = 1'b0; x_stall_i = 1'b0; x_kill_i = 1'b0;
    #1;
    tests++;
    if (x_rd_valid_o !== 1'b0 || x_stall_req_o !== 1'b0) begin
      fails++; $display("FAIL after_result: valid=%b stall=%b want 0 0", x_rd_valid_o, x_stall_req_o);
    end
    if (exp_core) begin
      cval = 1'b1; ca = a; cb = b; cs = sgn;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    x_stall_i = 1'b0; x_kill_i = 1'b0; d_valid_i = 1'b0; d_is_divide_i = 1'b0;
    d_fun_i = 3'd0; d_rs1_i = 32'd0; d_rs2_i = 32'd0;
    div_done_i = 1'b0; div_quot_i = 32'd0; div_rem_i = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({x_stall_req_o, x_rd_valid_o, div_start_o, div_signed_o, div_abort_o} !== 5'd0 ||
        x_rd_o !== 32'd0 || div_rs1_o !== 32'd0 || div_rs2_o !== 32'd0) begin
      fails++; $display("FAIL reset_outputs: rd=%h valid=%b stall=%b start=%b rs1=%h rs2=%h",
                        x_rd_o, x_rd_valid_o, x_stall_req_o, div_start_o, div_rs1_o, div_rs2_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    do_op(FUNC_DIVU, 32'd100, 32'd7, 34, 1'b0);
    do_op(FUNC_DIV, 32'd100, 32'd7, 12, 1'b0);
    do_op(FUNC_REM, 32'd100, 32'd7, 12, 1'b0);
    do_op(FUNC_DIV, 32'hFFFF_FFF9, 32'd2, 9, 1'b0);
    do_op(FUNC_REMU, 32'hFFFF_FFF9, 32'd2, 9, 1'b0);
    do_op(FUNC_REM, 32'h0000_1234, 32'd0, 5, 1'b0);
    do_op(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5, 1'b0);
    do_op(FUNC_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 3, 1'b0);
  endtask

  task automatic test_fast_kill;
    do_op(FUNC_DIVU, 32'hDEAD_BEEF, 32'd0, 5, 1'b1);
    do_op(FUNC_REMU, 32'hFFFF_FFF9, 32'd2, 5, 1'b1);
  endtask

  task automatic test_kill;
    int v0;
    core_lat = 20;
    @(negedge clk);
    d_valid_i = 1'b1; d_is_divide_i = 1'b1; d_fun_i = FUNC_DIVU;
    d_rs1_i = 32'd1000; d_rs2_i = 32'd9;
    @(negedge clk);
    d_valid_i = 1'b0;
    #1;
    tests++;
    if (div_start_o !== 1'b1) begin
      fails++; $display("FAIL kill_start: got %b want 1", div_start_o);
    end
    repeat (5) @(negedge clk);
    x_kill_i = 1'b1;
    #1;
    v0 = n_valid;
    tests++;
    if (div_abort_o !== 1'b1) begin
      fails++; $display("FAIL kill_abort: got %b want 1", div_abort_o);
    end
    @(negedge clk);
    x_kill_i = 1'b0;
    #1;
    tests++;
    if (x_stall_req_o !== 1'b0 || div_abort_o !== 1'b0) begin
      fails++; $display("FAIL kill_idle: stall=%b abort=%b want 0 0", x_stall_req_o, div_abort_o);
    end
    repeat (30) @(negedge clk);
    #2;
    tests++;
    if (n_valid !== v0) begin
      fails++; $display("FAIL kill_no_valid: %0d valid pulses want 0", n_valid - v0);
    end
    cval = 1'b0;
    do_op(FUNC_DIVU, 32'd1000, 32'd9, 8, 1'b0);
  endtask

  task automatic test_done_kill;
    int v0;
    core_lat = 6;
    @(negedge clk);
    d_valid_i = 1'b1; d_is_divide_i = 1'b1; d_fun_i = FUNC_DIV;
    d_rs1_i = 32'd12345; d_rs2_i = 32'hFFFF_FFFB;
    @(negedge clk);
    d_valid_i = 1'b0;
    #1;
    tests++;
    if (div_start_o !== 1'b1) begin
      fails++; $display("FAIL donekill_start: got %b want 1", div_start_o);
    end
    repeat (6) @(negedge clk);
    x_kill_i = 1'b1;
    #3;
    v0 = n_valid;
    tests++;
    if (div_abort_o !== 1'b1) begin
      fails++; $display("FAIL donekill_abort: got %b want 1 (done=%b)", div_abort_o, div_done_i);
    end
    @(negedge clk);
    x_kill_i = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    tests++;
    if (n_valid !== v0) begin
      fails++; $display("FAIL donekill_no_valid: %0d valid pulses want 0", n_valid - v0);
    end
    cval = 1'b0;
    do_op(FUNC_DIV, 32'd12345, 32'hFFFF_FFFB, 7, 1'b0);
  endtask

  task automatic test_reset_mid;
    core_lat = 30;
    @(negedge clk);
    d_valid_i = 1'b1; d_is_divide_i = 1'b1; d_fun_i = FUNC_DIV;
    d_rs1_i = 32'd999; d_rs2_i = 32'hFFFF_FFFD;
    @(negedge clk);
    d_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if ({x_stall_req_o, x_rd_valid_o, div_start_o, div_signed_o, div_abort_o} !== 5'd0 ||
        x_rd_o !== 32'd0 || div_rs1_o !== 32'd0 || div_rs2_o !== 32'd0) begin
      fails++; $display("FAIL reset_mid: rd=%h stall=%b signed=%b rs1=%h rs2=%h want all 0",
                        x_rd_o, x_stall_req_o, div_signed_o, div_rs1_o, div_rs2_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cval = 1'b0;
    do_op(FUNC_DIV, 32'd999, 32'hFFFF_FFFD, 10, 1'b0);
  endtask

  task automatic test_stall;
    int s0;
    s0 = n_start;
    @(negedge clk);
    d_valid_i = 1'b1; d_is_divide_i = 1'b0; d_fun_i = FUNC_DIVU;
    d_rs1_i = 32'd500; d_rs2_i = 32'd3; x_stall_i = 1'b0;
    #1;
    tests++;
    if (x_stall_req_o !== 1'b0) begin
      fails++; $display("FAIL not_divide: stall=%b want 0", x_stall_req_o);
    end
    @(negedge clk);
    d_is_divide_i = 1'b1; x_kill_i = 1'b1;
    #1;
    tests++;
    if (x_stall_req_o !== 1'b0) begin
      fails++; $display("FAIL kill_blocks_accept: stall=%b want 0", x_stall_req_o);
    end
    @(negedge clk);
    x_kill_i = 1'b0; x_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (x_stall_req_o !== 1'b0) begin
        fails++; $display("FAIL stall_blocks_accept: cycle %0d stall=%b want 0", i, x_stall_req_o);
      end
      @(negedge clk);
    end
    tests++;
    if (n_start !== s0) begin
      fails++; $display("FAIL stall_no_start: %0d starts want 0", n_start - s0);
    end
    do_op(FUNC_DIVU, 32'd500, 32'd3, 4, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [2:0] fun;
    a = 32'd1; b = 32'd1;
    for (int n = 0; n < 40; n++) begin
      fun = 3'b100 | 3'($urandom_range(0, 3));
      if (n == 0 || $urandom_range(0, 3) != 0) begin
        a = pick_operand();
        b = pick_operand();
      end
      do_op(fun, a, b, $urandom_range(1, 40), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_fast_kill();
    test_kill();
    test_done_kill();
    test_reset_mid();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
